character_anim_ctrl: RTL and testbench

- Animation/motion sequencer for one fighter.
- Turns player key levels and hit events into the `character1_state`, `frame_num`, `move_l` and `move_r` signals that drive the character sprite renderer.
- Runs on Clk, paced by the ~60 Hz frame_clk.
- One instance per player, placed between the keycode decoder and the sprite renderer.

---
 rtl/anim_pkg.sv | 39 +++
 rtl/frame_tick_sync.sv | 27 ++
 rtl/character_anim_ctrl.sv | 156 +++++++++++++++
 tb/tb_character_anim_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/anim_pkg.sv
// rtl/anim_pkg.sv - Animation state encodings, frame counts and sprite constants shared with the renderer
package anim_pkg;

    typedef enum logic [7:0] {
        ST_STAND  = 8'd0,
        ST_ATTACK = 8'd1,
        ST_MOVEL  = 8'd2,
        ST_MOVER  = 8'd3,
        ST_HURT   = 8'd4,
        ST_DEFEND = 8'd5
    } anim_state_t;

    localparam int ANIM_TICKS_PER_FRAME  = 6;
    localparam int ANIM_STAND_FRAMES     = 8;
    localparam int ANIM_MOVE_FRAMES      = 5;
    localparam int ANIM_ATTACK_FRAMES    = 9;
    localparam int ANIM_HURT_FRAMES      = 4;
    localparam int ANIM_ATTACK_HIT_FRAME = 4;

    localparam int SPRITE_W = 64;
    localparam int SPRITE_H = 96;

    // Decision from the idle-like states (stand and walking), highest priority first.
    function automatic anim_state_t pick_state(
        input logic hit_p,
        input logic attack,
        input logic defend,
        input logic left,
        input logic right
    );
        if (hit_p)              return ST_HURT;
        else if (attack)        return ST_ATTACK;
        else if (defend)        return ST_DEFEND;
        else if (left && !right) return ST_MOVEL;
        else if (right && !left) return ST_MOVER;
        else                    return ST_STAND;
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// rtl/frame_tick_sync.sv - Brings frame_clk into the Clk domain and emits a one-cycle tick per rising edge
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/character_anim_ctrl.sv
// rtl/character_anim_ctrl.sv - Per-fighter animation sequencer driving state, frame index and motion pulses
module character_anim_ctrl
    import anim_pkg::*;
#(
    parameter int TICKS_PER_FRAME  = anim_pkg::ANIM_TICKS_PER_FRAME,
    parameter int STAND_FRAMES     = anim_pkg::ANIM_STAND_FRAMES,
    parameter int MOVE_FRAMES      = anim_pkg::ANIM_MOVE_FRAMES,
    parameter int ATTACK_FRAMES    = anim_pkg::ANIM_ATTACK_FRAMES,
    parameter int HURT_FRAMES      = anim_pkg::ANIM_HURT_FRAMES,
    parameter int ATTACK_HIT_FRAME = anim_pkg::ANIM_ATTACK_HIT_FRAME
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_attack,
    input  logic       key_defend,
    input  logic       hit,
    output logic [7:0] character1_state,
    output logic [7:0] frame_num,
    output logic       move_l,
    output logic       move_r,
    output logic       strike,
    output logic       blocked
);

    localparam int               DIV_W     = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICKS_PER_FRAME - 1);
    localparam logic [7:0]       HIT_FRAME = 8'(ATTACK_HIT_FRAME);

    anim_state_t      state_q, state_d;
    logic [7:0]       frame_q, frame_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             pend_q, pend_d;
    logic             move_l_q, move_l_d;
    logic             move_r_q, move_r_d;
    logic             strike_q, strike_d;
    logic             blocked_q, blocked_d;

    logic             tick;
    logic             hit_now;
    logic             frame_step;
    logic [7:0]       last_frame;

    frame_tick_sync u_tick_sync (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    always_comb begin
        case (state_q)
            ST_STAND:           last_frame = 8'(STAND_FRAMES - 1);
            ST_MOVEL, ST_MOVER: last_frame = 8'(MOVE_FRAMES - 1);
            ST_ATTACK:          last_frame = 8'(ATTACK_FRAMES - 1);
            ST_HURT:            last_frame = 8'(HURT_FRAMES - 1);
            default:            last_frame = 8'd0;
        endcase
    end

    // A hit landing on the same cycle as the tick is treated as already pending.
    assign hit_now    = pend_q | hit;
    assign frame_step = tick && (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        div_d     = div_q;
        pend_d    = pend_q;
        move_l_d  = 1'b0;
        move_r_d  = 1'b0;
        strike_d  = 1'b0;
        blocked_d = 1'b0;

        if (tick) begin
            pend_d = 1'b0;
        end else if (hit && state_q != ST_HURT) begin
            pend_d = 1'b1;
        end

        if (tick) begin
            case (state_q)
                ST_STAND, ST_MOVEL, ST_MOVER: begin
                    state_d = pick_state(hit_now, key_attack, key_defend, key_left, key_right);
                end
                ST_ATTACK: begin
                    if (hit_now) begin
                        state_d = ST_HURT;
                    end else if (frame_step && frame_q == last_frame) begin
                        state_d = ST_STAND;
                    end
                end
                ST_HURT: begin
                    if (frame_step && frame_q == last_frame) begin
                        state_d = ST_STAND;
                    end
                end
                ST_DEFEND: begin
                    if (hit_now) begin
                        blocked_d = 1'b1;
                    end else if (!key_defend) begin
                        state_d = ST_STAND;
                    end
                end
                default: state_d = ST_STAND;
            endcase

            if (state_d != state_q || state_q == ST_DEFEND) begin
                frame_d = 8'd0;
                div_d   = '0;
            end else begin
                div_d = frame_step ? '0 : div_q + 1'b1;
                if (frame_step) begin
                    frame_d = (frame_q == last_frame) ? 8'd0 : frame_q + 8'd1;
                end
                strike_d = frame_step && state_q == ST_ATTACK && (frame_q + 8'd1) == HIT_FRAME;
            end

            // Every tick spent walking (including the entering tick) moves one pixel.
            move_l_d = (state_d == ST_MOVEL);
            move_r_d = (state_d == ST_MOVER);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_STAND;
            frame_q   <= 8'd0;
            div_q     <= '0;
            pend_q    <= 1'b0;
            move_l_q  <= 1'b0;
            move_r_q  <= 1'b0;
            strike_q  <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            div_q     <= div_d;
            pend_q    <= pend_d;
            move_l_q  <= move_l_d;
            move_r_q  <= move_r_d;
            strike_q  <= strike_d;
            blocked_q <= blocked_d;
        end
    end

    assign character1_state = state_q;
    assign frame_num        = frame_q;
    assign move_l           = move_l_q;
    assign move_r           = move_r_q;
    assign strike           = strike_q;
    assign blocked          = blocked_q;

endmodule

// File: tb/tb_character_anim_ctrl.sv
// tb/tb_character_anim_ctrl.sv - Scoreboard bench for character_anim_ctrl with a tick-count reference model
module tb_character_anim_ctrl;

    localparam int TPF = 2;

    logic       Clk        = 1'b0;
    logic       Reset      = 1'b1;
    logic       frame_clk  = 1'b0;
    logic       key_left   = 1'b0;
    logic       key_right  = 1'b0;
    logic       key_attack = 1'b0;
    logic       key_defend = 1'b0;
    logic       hit        = 1'b0;
    logic [7:0] character1_state;
    logic [7:0] frame_num;
    logic       move_l;
    logic       move_r;
    logic       strike;
    logic       blocked;

    always #5 Clk = ~Clk;

    character_anim_ctrl #(.TICKS_PER_FRAME(TPF)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .frame_clk        (frame_clk),
        .key_left         (key_left),
        .key_right        (key_right),
        .key_attack       (key_attack),
        .key_defend       (key_defend),
        .hit              (hit),
        .character1_state (character1_state),
        .frame_num        (frame_num),
        .move_l           (move_l),
        .move_r           (move_r),
        .strike           (strike),
        .blocked          (blocked)
    );

    typedef struct {
        int state;
        int frame;
        bit ml;
        bit mr;
        bit st;
        bit bl;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    // Model: state plus number of ticks spent in it since entry (entry tick = 0).
    int   m_state = 0;
    int   m_t     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int nframes(input int s);
        case (s)
            0:       return 8;
            1:       return 9;
            2, 3:    return 5;
            4:       return 4;
            default: return 1;
        endcase
    endfunction

    task automatic model_tick(input bit kl, input bit kr, input bit ka, input bit kd, input bit hit_raw);
        exp_t e;
        int   nxt;
        int   tt;
        bit   ph;
        e   = '{default: 0};
        ph  = hit_raw && (m_state != 4);
        nxt = m_state;
        tt  = m_t + 1;
        case (m_state)
            0, 2, 3: nxt = ph ? 4 : ka ? 1 : kd ? 5 : (kl && !kr) ? 2 : (kr && !kl) ? 3 : 0;
            1: if (ph) nxt = 4; else if (tt == 9 * TPF) nxt = 0;
            4: if (tt == 4 * TPF) nxt = 0;
            5: if (ph) e.bl = 1; else if (!kd) nxt = 0;
            default: nxt = 0;
        endcase
        m_t     = (nxt != m_state) ? 0 : tt;
        m_state = nxt;
        e.state = nxt;
        e.frame = (nxt == 5) ? 0 : (m_t / TPF) % nframes(nxt);
        e.ml    = (nxt == 2);
        e.mr    = (nxt == 3);
        e.st    = (nxt == 1) && (m_t == 4 * TPF);
        exp_q.push_back(e);
    endtask

    // hmode: 0 no hit, 1 hit well before the tick, 2 hit on the tick cycle itself.
    task automatic do_tick(input bit kl, input bit kr, input bit ka, input bit kd, input int hmode);
        @(negedge Clk);
        key_left = kl; key_right = kr; key_attack = ka; key_defend = kd;
        if (hmode == 1) begin
            hit = 1'b1;
            @(negedge Clk);
            hit = 1'b0;
        end
        @(negedge Clk);
        model_tick(kl, kr, ka, kd, hmode != 0);
        frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        if (hmode == 2) hit = 1'b1;
        @(negedge Clk);
        hit = 1'b0;
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk(tag, {character1_state, frame_num, move_l, move_r, strike, blocked}, 32'd0);
        repeat (2) @(negedge Clk);
        m_state = 0;
        m_t     = 0;
        Reset   = 1'b1;
    endtask

    // Outputs of a tick land on the third Clk edge after frame_clk is first sampled high.
    logic       fc_prev;
    logic [2:0] rise_hist;
    always @(posedge Clk) begin
        #1;
        if (!Reset || !mon_en) begin
            fc_prev   = 1'b0;
            rise_hist = 3'b000;
            cur       = '{default: 0};
        end else begin
            rise_hist = {rise_hist[1:0], frame_clk & ~fc_prev};
            fc_prev   = frame_clk;
            if (rise_hist[2]) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("state",   32'(character1_state), 32'(cur.state));
                    chk("frame",   32'(frame_num),        32'(cur.frame));
                    chk("move_l",  32'(move_l),           32'(cur.ml));
                    chk("move_r",  32'(move_r),           32'(cur.mr));
                    chk("strike",  32'(strike),           32'(cur.st));
                    chk("blocked", 32'(blocked),          32'(cur.bl));
                end
            end else begin
                chk("idle_hold", {character1_state, frame_num, move_l, move_r, strike, blocked},
                    {cur.state[7:0], cur.frame[7:0], 4'b0000});
            end
        end
    end

    initial begin
        bit kl, kr, ka, kd;
        int hm;
        #1;
        Reset = 1'b0;
        #2;
        chk("reset_initial", {character1_state, frame_num, move_l, move_r, strike, blocked}, 32'd0);
        repeat (3) @(negedge Clk);
        Reset  = 1'b1;
        mon_en = 1'b1;

        // Walk right 10 ticks plus one to see the frame wrap.
        repeat (11) do_tick(0, 1, 0, 0, 0);
        // Opposite key alone, then both keys from MOVEL.
        repeat (2) do_tick(1, 0, 0, 0, 0);
        repeat (2) do_tick(1, 1, 0, 0, 0);
        // One-shot attack runs to completion.
        do_tick(0, 0, 1, 0, 0);
        repeat (19) do_tick(0, 0, 0, 0, 0);
        // Hit during attack frame 2 aborts into hurt; hits inside hurt are discarded.
        do_tick(0, 0, 1, 0, 0);
        repeat (4) do_tick(0, 0, 0, 0, 0);
        do_tick(0, 0, 0, 0, 1);
        do_tick(0, 0, 0, 0, 1);
        do_tick(0, 0, 0, 0, 2);
        repeat (7) do_tick(0, 0, 0, 0, 0);
        // Defend blocks both early and same-cycle hits.
        do_tick(0, 0, 0, 1, 0);
        do_tick(0, 0, 0, 1, 1);
        do_tick(0, 0, 0, 1, 2);
        do_tick(0, 0, 0, 0, 0);
        // Same-cycle hit from stand.
        do_tick(0, 0, 0, 0, 2);
        repeat (8) do_tick(0, 0, 0, 0, 0);
        // Reset mid-attack at frame 5, then no change until a tick arrives.
        do_tick(0, 0, 1, 0, 0);
        repeat (10) do_tick(0, 0, 0, 0, 0);
        reset_pulse("reset_mid_attack");
        key_attack = 1'b1;
        repeat (6) @(negedge Clk);
        do_tick(0, 0, 1, 0, 0);
        repeat (18) do_tick(0, 0, 0, 0, 0);

        kl = 0; kr = 0; ka = 0; kd = 0;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                kl = 1'($urandom_range(0, 1));
                kr = 1'($urandom_range(0, 1));
                ka = ($urandom_range(0, 5) == 0);
                kd = ($urandom_range(0, 4) == 0);
            end
            hm = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 2)) : 0;
            do_tick(kl, kr, ka, kd, hm);
        end

        repeat (5) @(negedge Clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
